// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer: state encoding and default width.
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/countdown_timer_decrement.sv
// Ripple-borrow decrementer: result = value - 1 (wraps at zero, never used there).
module countdown_timer_decrement
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] borrow;

  // Borrow enters at bit 0 and ripples up through every zero bit.
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_borrow
    assign borrow[i+1] = borrow[i] & ~value[i];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_diff
    assign result[i] = value[i] ^ borrow[i];
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse and optional auto-reload.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | count holds, enable ignored, busy=0
//   ST_RUN  | count != 0, decrements on enable, busy=1
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] TERM_COUNT = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] count_dec;
  logic             at_term;

  countdown_timer_decrement #(
    .WIDTH(WIDTH)
  ) u_decrement (
    .value (count),
    .result(count_dec)
  );

  // Terminal edge is the enabled decrement out of count==1.
  assign at_term = (count == TERM_COUNT);
  assign zero    = (count == '0);

  // Timer FSM: reset > load > enabled decrement > hold; outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      reload_reg <= '0;
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (load) begin
      // A zero load parks in IDLE so RUN never holds count==0.
      count      <= load_value;
      reload_reg <= load_value;
      done       <= 1'b0;
      if (load_value != '0) begin
        state <= ST_RUN;
        busy  <= 1'b1;
      end else begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end
    end else if (state == ST_RUN && enable) begin
      if (at_term) begin
        done <= 1'b1;
        if (auto_reload) begin
          count <= reload_reg;
        end else begin
          count <= '0;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        count <= count_dec;
        done  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a per-cycle reference model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic       enable = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] count;
  logic       zero;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model: the timer is running exactly when the remaining count is nonzero.
  int m_count = 0;
  int m_reload = 0;
  int m_done = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .auto_reload(auto_reload),
    .count      (count),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_count  <= 0;
      m_reload <= 0;
      m_done   <= 0;
    end else if (load) begin
      m_count  <= int'(load_value);
      m_reload <= int'(load_value);
      m_done   <= 0;
    end else if (enable && m_count != 0) begin
      if (m_count == 1) begin
        m_done  <= 1;
        m_count <= auto_reload ? m_reload : 0;
      end else begin
        m_count <= m_count - 1;
        m_done  <= 0;
      end
    end else begin
      m_done <= 0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_count", int'(count), m_count);
      chk("model_zero", int'(zero), int'(m_count == 0));
      chk("model_busy", int'(busy), int'(m_count != 0));
      chk("model_done", int'(done), m_done);
    end
  end

  task automatic step(input logic l, input logic [7:0] lv, input logic en,
                      input logic ar, input logic rs);
    load        = l;
    load_value  = lv;
    enable      = en;
    auto_reload = ar;
    reset       = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_basic[5] = '{4, 3, 2, 1, 0};
  int exp_gate_en[4] = '{1, 0, 0, 1};
  int exp_gate[4] = '{3, 3, 3, 2};
  int exp_ar[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
  int cyc;

  initial begin
    // 1 reset
    step(0, 8'd0, 0, 0, 1);
    check_en = 1'b1;
    chk("reset_count", int'(count), 0);
    chk("reset_zero", int'(zero), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);

    // 2 basic countdown from 5
    step(1, 8'd5, 0, 0, 0);
    chk("basic_load", int'(count), 5);
    chk("basic_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'd0, 1, 0, 0);
      chk("basic_count", int'(count), exp_basic[i]);
      chk("basic_done", int'(done), int'(i == 4));
    end
    chk("basic_busy_fall", int'(busy), 0);
    step(0, 8'd0, 1, 0, 0);
    chk("basic_hold0", int'(count), 0);
    chk("basic_no_redone", int'(done), 0);

    // 3 enable gating
    step(1, 8'd4, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'd0, exp_gate_en[i][0], 0, 0);
      chk("gate_count", int'(count), exp_gate[i]);
      chk("gate_done", int'(done), 0);
    end

    // 4 auto-reload period 3, then drop auto_reload mid-count
    step(1, 8'd3, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'd0, 1, 1, 0);
      chk("ar_count", int'(count), exp_ar[i]);
      chk("ar_done", int'(done), int'(exp_ar[i] == 3));
      chk("ar_busy", int'(busy), 1);
    end
    step(0, 8'd0, 1, 1, 0);
    step(0, 8'd0, 1, 0, 0);
    step(0, 8'd0, 1, 0, 0);
    chk("ar_off_count", int'(count), 0);
    chk("ar_off_done", int'(done), 1);
    chk("ar_off_busy", int'(busy), 0);

    // reload value 1: done every enabled cycle
    step(1, 8'd1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'd0, 1, 1, 0);
      chk("ar1_done", int'(done), 1);
      chk("ar1_count", int'(count), 1);
    end

    // 5 load mid-count and on the terminal edge
    step(1, 8'd5, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'd0, 1, 0, 0);
    chk("mid_pre", int'(count), 2);
    step(1, 8'd9, 1, 0, 0);
    chk("mid_load", int'(count), 9);
    chk("mid_done", int'(done), 0);
    for (int i = 0; i < 8; i++) step(0, 8'd0, 1, 0, 0);
    chk("term_pre", int'(count), 1);
    step(1, 8'd7, 1, 0, 0);
    chk("term_load", int'(count), 7);
    chk("term_done", int'(done), 0);
    chk("term_busy", int'(busy), 1);

    // 6 reset mid-run, zero load, full range
    for (int i = 0; i < 3; i++) step(0, 8'd0, 1, 0, 0);
    chk("rst_pre", int'(count), 4);
    step(0, 8'd0, 1, 0, 1);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    step(0, 8'd0, 1, 1, 0);
    chk("idle_ignore_en", int'(count), 0);
    step(1, 8'd0, 1, 0, 0);
    chk("load0_busy", int'(busy), 0);
    chk("load0_zero", int'(zero), 1);
    step(0, 8'd0, 1, 0, 0);
    chk("load0_done", int'(done), 0);
    step(1, 8'hFF, 0, 0, 0);
    cyc = 0;
    do begin
      step(0, 8'd0, 1, 0, 0);
      cyc++;
    end while (!done && cyc < 300);
    chk("full_range_cycles", cyc, 255);
    chk("full_range_count", int'(count), 0);

    step(0, 8'd0, 0, 0, 0);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
